// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a wrap-around RAM address range and streams the words out over valid/ready
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEFT_ONE = 1;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] issue_ptr_q, issue_ptr_d;
    logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]   out_left_q, out_left_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            count_q, count_d;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;
    logic [1:0]            slot;

    // next state: credit-gated issue, 2-entry buffer push/pop, command and completion handling
    always_comb begin
        pop          = (count_q != 2'd0) && out_ready;
        occ          = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue        = (state_q == RUN) && (issue_left_q != '0) && (occ < 3'd2);
        slot         = count_q - {1'b0, pop};
        buf0_d       = pop ? buf1_q : buf0_q;
        buf1_d       = buf1_q;
        if (inflight_q) begin
            if (slot == 2'd0) buf0_d = ram_q;
            else              buf1_d = ram_q;
        end
        count_d      = count_q + {1'b0, inflight_q} - {1'b0, pop};
        inflight_d   = issue;
        issue_ptr_d  = issue ? issue_ptr_q + PTR_ONE : issue_ptr_q;
        issue_left_d = issue ? issue_left_q - LEFT_ONE : issue_left_q;
        out_left_d   = pop ? out_left_q - LEFT_ONE : out_left_q;
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        if (state_q == IDLE && start) begin
            if (length != '0) begin
                state_d      = RUN;
                busy_d       = 1'b1;
                issue_ptr_d  = base_addr;
                issue_left_d = length;
                out_left_d   = length;
            end else begin
                done_d = 1'b1;
            end
        end
        if (state_q == RUN && pop && out_left_q == LEFT_ONE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    // state registers, cleared asynchronously so a reset discards any buffered words at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            inflight_q   <= 1'b0;
            issue_ptr_q  <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            inflight_q   <= inflight_d;
            issue_ptr_q  <= issue_ptr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            count_q      <= count_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_addr  = issue_ptr_q;
    assign out_data  = buf0_q;
    assign out_valid = count_q != 2'd0;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed and randomized runs checked against a queue-based stream model
module tb_ram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, out_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q, out_data;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] addr_l = '0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    // RAM with a registered read address
    always @(posedge clk) addr_l <= ram_addr;
    assign ram_q = mem[addr_l];

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low in cycles 3..10, 3: random ready plus a start poke while busy
    task automatic run(input int b, input int len, input int mode);
        logic [DW-1:0] q[$];
        logic [DW-1:0] e;
        int cyc;
        bit fin;
        for (int i = 0; i < len; i++) q.push_back(mem[(b + i) % DEPTH]);
        base_addr = AW'(b);
        length = (AW+1)'(len);
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        if (len == 0) begin
            chk("zl_busy", 32'(busy), 0);
            chk("zl_done", 32'(done), 1);
            tick;
            chk("zl_done_once", 32'(done), 0);
            repeat (4) begin
                chk("zl_valid", 32'(out_valid), 0);
                chk("zl_busy_low", 32'(busy), 0);
                tick;
            end
            return;
        end
        fin = 1'b0;
        while (!fin && cyc < 2000) begin
            chk("busy_high", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            out_ready = (mode == 0) ? 1'b1 :
                        (mode == 2) ? !(cyc >= 3 && cyc <= 10) : 1'($urandom_range(0, 1));
            if (mode == 3 && cyc == 4) begin
                start = 1'b1;
                base_addr = AW'(b + 17);
                length = (AW+1)'(5);
            end else begin
                start = 1'b0;
            end
            if (mode == 0 && cyc < 3) chk("early_valid", 32'(out_valid), 0);
            if (mode == 0 && cyc >= 3) chk("no_bubble", 32'(out_valid), 1);
            if (mode == 2 && cyc >= 3 && cyc <= 10) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(mem[b % DEPTH]));
                chk("hold_addr", 32'(ram_addr), (b + 2) % DEPTH);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_word", 1, 0);
                    fin = 1'b1;
                end else begin
                    e = q.pop_front();
                    chk("data", 32'(out_data), 32'(e));
                    if (q.size() == 0) fin = 1'b1;
                end
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        chk("done_pulse", 32'(done), 1);
        chk("busy_fall", 32'(busy), 0);
        out_ready = 1'b0;
        tick;
        chk("done_once", 32'(done), 0);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        repeat (2) tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        rst = 1'b0;
        tick;
        run(4, 4, 0);
        run(4, 4, 2);
        run(62, 4, 0);
        run(0, 0, 0);
        run(0, 64, 0);
        // reset while two words sit in the buffer
        out_ready = 1'b0;
        base_addr = AW'(4);
        length = (AW+1)'(4);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_addr", 32'(ram_addr), 0);
        #3 rst = 1'b0;
        tick;
        chk("post_rst_done", 32'(done), 0);
        run(10, 6, 0);
        run(20, 5, 3);
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        repeat (12) run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), 1);
        run(int'($urandom_range(0, DEPTH - 1)), 9, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Sequential read engine that sits directly downstream of the input RAM. On a start command it walks a contiguous, wrap-around address range and streams the words out on a valid/ready interface. It absorbs the RAM's one-cycle registered-address read latency with a 2-entry output buffer, so backpressure never loses a word and the stream sustains one word per cycle when the consumer is always ready.

## Interface
- DATA_WIDTH, 8, width of a RAM word and of out_data
- ADDR_WIDTH, 6, RAM address width; RAM depth is 2**ADDR_WIDTH
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous and active-high
- start  input  1  command strobe, sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first address, sampled with start
- length  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH, sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last word is accepted
- ram_addr  output  ADDR_WIDTH  read address to the RAM (registered)
- ram_q  input  DATA_WIDTH  RAM read data, valid the cycle after ram_addr is latched by the RAM
- out_data  output  DATA_WIDTH  stream data, the head of the buffer
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready from the consumer

## Operation
- Reset values: state IDLE, busy 0, done 0, ram_addr 0, out_valid 0, out_data 0, buffer empty, inflight 0, counters 0.
- Counters:
  - issue_ptr (ADDR_WIDTH) drives ram_addr.
  - issue_left (ADDR_WIDTH+1) counts addresses not yet issued.
  - out_left (ADDR_WIDTH+1) counts words not yet accepted by the consumer.
  - inflight (1 bit) marks an issued read whose data returns this cycle.
- States:
  - IDLE: if start and length != 0, load issue_ptr=base_addr, issue_left=out_left=length, go to RUN. If start and length == 0, go nowhere, keep busy low, and pulse done the next cycle. Otherwise hold.
  - RUN: issue a read when issue_left != 0 and (buffer_count + inflight − pop) < 2, where pop = out_valid & out_ready. Each issue increments issue_ptr modulo 2**ADDR_WIDTH (wrap from max address to 0), decrements issue_left, and sets inflight for the next cycle.
  - Data capture: when inflight is 1, push ram_q into the buffer on that edge.
  - Transfer: each pop decrements out_left. The pop that takes out_left to 0 moves the state to IDLE and pulses done.
- The buffer is a 2-entry FIFO. out_valid = buffer not empty, and out_data = head. A push and a pop in the same cycle are both honoured. The credit rule guarantees the buffer never overflows.
- The RAM re-latches ram_addr every cycle. This is harmless because data is captured only when inflight is set.
- start while busy is ignored.
- The block drives no RAM write enable. RAM writes to the active range while busy give undefined data, and that case is not checked.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. Buffered words are discarded and no done pulse is issued.

## Timing
- Edge 0 samples start. Cycle 1: busy=1, ram_addr=base. Edge 1: RAM latches base. Cycle 2: ram_q=mem[base]. Edge 2: pushed to buffer. Cycle 3: out_valid=1, out_data=mem[base].
- First-word latency is 3 cycles from the start edge.
- With out_ready held high, word k appears in cycle 3+k, and done pulses in the cycle after the last word is accepted.
- With out_ready low, at most 2 words are buffered and issue stalls. After out_ready rises, the next word follows without a bubble.
- done is high for exactly one cycle, and busy falls in the same cycle done rises.

## Test plan
- Preload mem[i]=i. Run start, base=4, length=4, out_ready=1 -> out_data 4,5,6,7 in cycles 3–6, then done pulses once and busy returns to 0.
- Same run with out_ready low for cycles 3–10 -> out_valid stays 1 with data 4, ram_addr stops advancing after 2 issues, and the full sequence 4..7 is delivered with no loss or duplication after release.
- base=62, length=4, ADDR_WIDTH=6 -> data 62,63,0,1 (address wrap).
- length=0 -> busy stays 0, done pulses once, and out_valid never rises. A full-depth run with length=64, base=0 -> data 0..63, all 64 words.
- Assert rst while 2 words are buffered mid-run -> out_valid, busy, done and ram_addr are all 0 on the same cycle. A new start after deassert runs cleanly.
- start pulsed again while busy with different base/length -> ignored, and the original sequence completes unchanged.
